mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter -- three-requester arbiter for a single-ported byte memory.
//
// Requesters: bit0 screen, bit1 cpu, bit2 gpu. Each requester presents a read
// and/or write request with a packed index and write byte; the winner gets a
// one-cycle req_ack pulse when its operation completes. Only one memory
// operation is ever outstanding.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_rd, req_wr [2:0]    per-requester read / write requests
//   req_idx   [3*ADDR_W]    per-requester index, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata [3*DATA_W]    per-requester write byte, packed likewise
//   req_ack   [2:0]         one-cycle completion pulse (one-hot or zero)
//   rdata                   read data, valid while the matching req_ack bit is high
//   mem_read, mem_write     memory strobes (never both high)
//   mem_read_idx, mem_write_idx, mem_write_byte   memory address/data
//   mem_read_byte, mem_read_ack                   memory read return
//   err                     sticky read-timeout flag
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority screen > cpu > gpu.
module mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req_rd,
    input  logic [2:0]            req_wr,
    input  logic [3*ADDR_W-1:0]   req_idx,
    input  logic [3*DATA_W-1:0]   req_wdata,
    output logic [2:0]            req_ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_read_idx,
    output logic [ADDR_W-1:0]     mem_write_idx,
    output logic [DATA_W-1:0]     mem_write_byte,
    input  logic [DATA_W-1:0]     mem_read_byte,
    input  logic                  mem_read_ack,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          win, win_nxt;
    logic [7:0]          cnt, cnt_nxt;
    logic [2:0]          pending;
    logic [1:0]          prio_start;
    logic [1:0]          grant_id;

    logic [2:0]          req_ack_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic                mem_read_nxt;
    logic                mem_write_nxt;
    logic [ADDR_W-1:0]   mem_read_idx_nxt;
    logic [ADDR_W-1:0]   mem_write_idx_nxt;
    logic [DATA_W-1:0]   mem_write_byte_nxt;
    logic                err_nxt;

    // First requester with a pending bit, searching upward (mod 3) from start.
    function automatic logic [1:0] pick(input logic [2:0] pend, input logic [1:0] start);
        logic [1:0] sel;
        int         j;
        sel = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            j = (int'(start) + k) % 3;
            if (pend[j]) sel = 2'(j);
        end
        return sel;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    // rr_ptr holds the highest-priority requester for the next grant.
    logic [1:0] rr_ptr, rr_ptr_nxt;
    assign prio_start = rr_ptr;
`else
    assign prio_start = 2'd0;
`endif

    // A requester keeps its request up through its ack cycle, so the
    // requester being acknowledged right now must not win again.
    assign pending  = (req_rd | req_wr) & ~req_ack;
    assign grant_id = pick(pending, prio_start);

    always_comb begin
        state_nxt          = state;
        win_nxt            = win;
        cnt_nxt            = cnt;
        req_ack_nxt        = 3'b000;
        rdata_nxt          = rdata;
        mem_read_nxt       = 1'b0;
        mem_write_nxt      = 1'b0;
        mem_read_idx_nxt   = mem_read_idx;
        mem_write_idx_nxt  = mem_write_idx;
        mem_write_byte_nxt = mem_write_byte;
        err_nxt            = err;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_nxt         = rr_ptr;
`endif

        case (state)
            IDLE: begin
                if (|pending) begin
                    win_nxt = grant_id;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_nxt = (grant_id == 2'd2) ? 2'd0 : grant_id + 2'd1;
`endif
                    // rd+wr together is treated as a write
                    if (req_wr[grant_id]) begin
                        mem_write_nxt      = 1'b1;
                        mem_write_idx_nxt  = req_idx[int'(grant_id)*ADDR_W +: ADDR_W];
                        mem_write_byte_nxt = req_wdata[int'(grant_id)*DATA_W +: DATA_W];
                        req_ack_nxt        = 3'b001 << grant_id;
                    end else begin
                        mem_read_nxt     = 1'b1;
                        mem_read_idx_nxt = req_idx[int'(grant_id)*ADDR_W +: ADDR_W];
                        cnt_nxt          = 8'd1;
                        state_nxt        = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                if (mem_read_ack) begin
                    rdata_nxt   = mem_read_byte;
                    req_ack_nxt = 3'b001 << win;
                    cnt_nxt     = 8'd0;
                    state_nxt   = ACK;
                end else if (cnt == 8'(TIMEOUT)) begin
                    // give up: complete the read with zero data and flag it
                    rdata_nxt   = '0;
                    req_ack_nxt = 3'b001 << win;
                    err_nxt     = 1'b1;
                    cnt_nxt     = 8'd0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            ACK: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            win            <= 2'd0;
            cnt            <= 8'd0;
            req_ack        <= 3'b000;
            rdata          <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_read_idx   <= '0;
            mem_write_idx  <= '0;
            mem_write_byte <= '0;
            err            <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr         <= 2'd0;
`endif
        end else begin
            state          <= state_nxt;
            win            <= win_nxt;
            cnt            <= cnt_nxt;
            req_ack        <= req_ack_nxt;
            rdata          <= rdata_nxt;
            mem_read       <= mem_read_nxt;
            mem_write      <= mem_write_nxt;
            mem_read_idx   <= mem_read_idx_nxt;
            mem_write_idx  <= mem_write_idx_nxt;
            mem_write_byte <= mem_write_byte_nxt;
            err            <= err_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr         <= rr_ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (default parameters). Stimulus pushes the
// expected memory strobes and acks (with their cycle numbers) into queues; a
// negedge monitor pops and compares whenever the DUT shows an event.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      req_rd, req_wr;
    logic [3*AW-1:0] req_idx;
    logic [3*DW-1:0] req_wdata;
    logic [2:0]      req_ack;
    logic [DW-1:0]   rdata;
    logic            mem_read, mem_write;
    logic [AW-1:0]   mem_read_idx, mem_write_idx;
    logic [DW-1:0]   mem_write_byte;
    logic [DW-1:0]   mem_read_byte;
    logic            mem_read_ack;
    logic            err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_rd         (req_rd),
        .req_wr         (req_wr),
        .req_idx        (req_idx),
        .req_wdata      (req_wdata),
        .req_ack        (req_ack),
        .rdata          (rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_idx   (mem_read_idx),
        .mem_write_idx  (mem_write_idx),
        .mem_write_byte (mem_write_byte),
        .mem_read_byte  (mem_read_byte),
        .mem_read_ack   (mem_read_ack),
        .err            (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        logic [2:0]  who;
        logic [11:0] idx;
        logic [7:0]  data;
        bit          chk_d;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t aq[$];

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        vectors++;
        errors++;
        $display("FAIL %s: event seen at cycle %0d with nothing expected", nm, cyc);
    endtask

    // ---------------- memory model ----------------
    // mem_lat = cycles from the mem_read cycle to the ack cycle; 0 = never ack.
    int          mem_lat = 1;
    bit          rd_pending = 0;
    int          rd_wait = 0;
    logic [11:0] rd_addr = '0;
    bit          spur_req = 0;

    initial begin
        mem_read_ack  = 1'b0;
        mem_read_byte = '0;
    end

    always @(posedge clk) begin
        #1;
        mem_read_ack = 1'b0;
        if (spur_req) begin
            mem_read_ack  = 1'b1;
            mem_read_byte = 8'hEE;
            spur_req      = 0;
        end
        if (rd_pending) begin
            rd_wait--;
            if (rd_wait == 0) begin
                mem_read_ack  = 1'b1;
                mem_read_byte = rd_addr[7:0] ^ 8'h7A;
                rd_pending    = 0;
            end
        end
        if (mem_read && mem_lat > 0) begin
            rd_pending = 1;
            rd_wait    = mem_lat;
            rd_addr    = mem_read_idx;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (mem_read && mem_write) unexpected("rd_wr_both_high");
        if (!$onehot0(req_ack)) unexpected("ack_not_onehot");
        if (mem_write) begin
            if (wq.size() == 0) unexpected("mem_write");
            else begin
                e = wq.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_idx", {20'b0, mem_write_idx}, {20'b0, e.idx});
                chk("wr_byte", {24'b0, mem_write_byte}, {24'b0, e.data});
            end
        end
        if (mem_read) begin
            if (rq.size() == 0) unexpected("mem_read");
            else begin
                e = rq.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_idx", {20'b0, mem_read_idx}, {20'b0, e.idx});
            end
        end
        if (req_ack != 3'b000) begin
            if (aq.size() == 0) unexpected("req_ack");
            else begin
                e = aq.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_who", {29'b0, req_ack}, {29'b0, e.who});
                if (e.chk_d) chk("ack_rdata", {24'b0, rdata}, {24'b0, e.data});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ack"}, {29'b0, req_ack}, 0);
        chk({tag, "_rdata"}, {24'b0, rdata}, 0);
        chk({tag, "_mem_read"}, {31'b0, mem_read}, 0);
        chk({tag, "_mem_write"}, {31'b0, mem_write}, 0);
        chk({tag, "_mem_read_idx"}, {20'b0, mem_read_idx}, 0);
        chk({tag, "_mem_write_idx"}, {20'b0, mem_write_idx}, 0);
        chk({tag, "_mem_write_byte"}, {24'b0, mem_write_byte}, 0);
        chk({tag, "_err"}, {31'b0, err}, 0);
    endtask

    // One requester issues one operation, holds it through its ack, drops it
    // on the following edge.
    task automatic req_once(input int who, input bit rd, input bit wr,
                            input logic [11:0] idx, input logic [7:0] wd);
        int c;
        bit got;
        logic [2:0] oh;
        oh = 3'b001 << who;
        @(posedge clk); #1;
        req_rd[who] = rd;
        req_wr[who] = wr;
        req_idx[who*AW +: AW]   = idx;
        req_wdata[who*DW +: DW] = wd;
        c = cyc;
        if (wr) begin
            wq.push_back('{c + 1, oh, idx, wd, 1'b0});
            aq.push_back('{c + 1, oh, 12'h0, 8'h0, 1'b0});
        end else begin
            rq.push_back('{c + 1, oh, idx, 8'h0, 1'b0});
            if (mem_lat > 0)
                aq.push_back('{c + 2 + mem_lat, oh, 12'h0, idx[7:0] ^ 8'h7A, 1'b1});
            else
                aq.push_back('{c + 1 + TO, oh, 12'h0, 8'h00, 1'b1});
        end
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (req_ack[who]) got = 1;
        end
        if (!got) unexpected("req_once_no_ack");
        @(posedge clk); #1;
        req_rd[who] = 1'b0;
        req_wr[who] = 1'b0;
    endtask

    initial begin
        int c;
        int acks;
        int ord[4];
        logic [11:0] cidx[3];

        rst_n     = 1'b0;
        req_rd    = '0;
        req_wr    = '0;
        req_idx   = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // cpu read 0x020, memory answers 0x5A one cycle later
        mem_lat = 1;
        req_once(1, 1'b1, 1'b0, 12'h020, 8'h00);
        // gpu write 0xFF to 0x1F0
        req_once(2, 1'b0, 1'b1, 12'h1F0, 8'hFF);
        // cpu rd+wr together -> write only
        req_once(1, 1'b1, 1'b1, 12'h030, 8'h77);
        // screen read with a slower memory
        mem_lat = 3;
        req_once(0, 1'b1, 1'b0, 12'h444, 8'h00);

        // stray memory ack while idle must be ignored
        @(posedge clk); #2;
        spur_req = 1;
        repeat (3) @(negedge clk);
        chk("stray_ack_rdata_kept", {24'b0, rdata}, {24'b0, 8'h44 ^ 8'h7A});
        req_once(0, 1'b0, 1'b1, 12'h00A, 8'h3C);

        // all three read continuously
        mem_lat = 1;
`ifdef ARB_ROUND_ROBIN_EN
        ord = '{0, 1, 2, 0};
`else
        ord = '{0, 0, 0, 0};
`endif
        cidx = '{12'h100, 12'h200, 12'h300};
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) req_idx[i*AW +: AW] = cidx[i];
        req_rd = 3'b111;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            rq.push_back('{c + 1 + 4*k, 3'b001 << ord[k], cidx[ord[k]], 8'h0, 1'b0});
            aq.push_back('{c + 3 + 4*k, 3'b001 << ord[k], 12'h0,
                           cidx[ord[k]][7:0] ^ 8'h7A, 1'b1});
        end
        acks = 0;
        for (int n = 0; n < 60 && acks < 4; n++) begin
            @(negedge clk);
            if (req_ack != 3'b000) acks++;
        end
        req_rd = 3'b000;
        if (acks < 4) unexpected("contention_ack_count");

        // reset while in RD_WAIT; the late memory ack must not produce req_ack
        mem_lat = 6;
        repeat (2) @(posedge clk); #1;
        req_rd[1] = 1'b1;
        req_idx[1*AW +: AW] = 12'h0AB;
        c = cyc;
        rq.push_back('{c + 1, 3'b010, 12'h0AB, 8'h0, 1'b0});
        repeat (3) @(negedge clk);
        rst_n  = 1'b0;
        req_rd = 3'b000;
        @(negedge clk);
        chk_all_zero("rst_in_rdwait");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_no_ack_err", {31'b0, err}, 0);
        mem_lat = 1;
        req_once(2, 1'b0, 1'b1, 12'h2B2, 8'hA1);

        // memory never answers: timeout, zero data, sticky err
        mem_lat = 0;
        chk("err_before_timeout", {31'b0, err}, 0);
        req_once(2, 1'b1, 1'b0, 12'h3C3, 8'h00);
        @(negedge clk);
        chk("err_after_timeout", {31'b0, err}, 1);
        mem_lat = 1;
        req_once(0, 1'b0, 1'b1, 12'h005, 8'h11);
        @(negedge clk);
        chk("err_sticky", {31'b0, err}, 1);

        repeat (10) @(negedge clk);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("aq_drained", aq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
